sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Bridges a 32-bit MEM-stage load/store port onto a 16-bit
//            asynchronous SRAM. Each access is two half-word beats (low then
//            high), and each beat is held for WAIT_CYCLES cycles. The pipeline
//            is frozen through ready while an access is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] C_BASE      = 32'(ADDR_BASE);
  localparam logic [3:0]  C_LAST_BEAT = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_count;
  logic        r_is_write;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [16:0] w_word;
  logic        w_request;
  logic        w_beat_end;

  assign w_request  = wr_en | rd_en;
  // Offset wraps modulo 2^32 below the base; byte lanes are dropped, then the
  // index is truncated to the 17 bits the SRAM can address.
  assign w_word     = 17'((address - C_BASE) >> 2);
  assign w_beat_end = (r_count == C_LAST_BEAT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Beat counter: counts cycles inside LOW/HIGH and clears on each phase change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= 4'd0;
    else if ((r_state == LOW || r_state == HIGH) && !w_beat_end)
      r_count <= r_count + 4'd1;
    else
      r_count <= 4'd0;
  end

  // Latch the request in IDLE so later input changes cannot disturb the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_write <= 1'b0;
      r_word     <= 17'd0;
      r_wdata    <= 32'd0;
    end else if (r_state == IDLE && w_request) begin
      r_is_write <= wr_en;
      r_word     <= w_word;
      r_wdata    <= write_data;
    end
  end

  // Sample SRAM read data on the last cycle of each beat; holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= 32'd0;
    end else if (!r_is_write && w_beat_end) begin
      if (r_state == LOW)       read_data[15:0]  <= sram_dq_in;
      else if (r_state == HIGH) read_data[31:16] <= sram_dq_in;
    end
  end

  // Next-state logic and SRAM bus / ready decode.
  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    sram_addr    = 18'd0;
    sram_dq_out  = 16'd0;
    sram_dq_oe   = 1'b0;
    sram_we_n    = 1'b1;
    case (r_state)
      IDLE: begin
        ready = ~w_request;
        if (w_request) w_next_state = LOW;
      end
      LOW: begin
        sram_addr = {r_word, 1'b0};
        if (r_is_write) begin
          sram_dq_out = r_wdata[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (w_beat_end) w_next_state = HIGH;
      end
      HIGH: begin
        sram_addr = {r_word, 1'b1};
        if (r_is_write) begin
          sram_dq_out = r_wdata[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (w_beat_end) w_next_state = DONE;
      end
      DONE: begin
        ready        = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire
